// File: rtl/intr_pkg.sv
// Shared definitions for the CPU-side interrupt entry logic: source
// numbering, io-bus register address and the entry sequencer states.
package intr_pkg;

    localparam int NIRQ = 5;

    // Source indices; a lower index means a higher priority.
    localparam int IRQ_UART  = 0;
    localparam int IRQ_CLOCK = 1;
    localparam int IRQ_TIMER = 2;
    localparam int IRQ_SWI   = 3;
    localparam int IRQ_SD    = 4;

    // io-bus address of the interrupt controller pending register.
    localparam logic [3:0] IO_PENDING_ADDR = 4'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        TAKE = 2'd3
    } state_t;

endpackage

// File: rtl/intr_prio_enc.sv
// Lowest-index-first priority encoder over the pending sources.
// found is 0 and idx is 0 when nothing is pending.
import intr_pkg::*;

module intr_prio_enc (
    input  logic [NIRQ-1:0] req,
    output logic            found,
    output logic [2:0]      idx
);

    // Scan from the lowest priority upward so the lowest set bit wins.
    always_comb begin
        found = 1'b0;
        idx   = 3'd0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                found = 1'b1;
                idx   = 3'(i);
            end
        end
    end

endmodule

// File: rtl/intr_entry.sv
// CPU-side interrupt entry: reads the pending register over the io bus,
// picks the highest-priority source, waits for an instruction boundary and
// redirects the core to the source's vector, saving the return PC and cause.
// Optional nesting (two levels, saved {epc, cause} stack) is enabled by
// defining INTR_ENTRY_NEST_EN; the default build supports one level only.
import intr_pkg::*;

module intr_entry #(
    parameter int              PC_W       = 32,
    parameter logic [PC_W-1:0] VEC_BASE   = PC_W'(32'h0000_0100),
    parameter int              VEC_STRIDE = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            interrupt,
    input  logic            insn_boundary,
    input  logic [PC_W-1:0] pc,
    input  logic            rti,
    input  logic            ie_wr,
    input  logic            ie_wdata,
    output logic            io_req,
    input  logic            io_grant,
    output logic [3:0]      io_addr,
    input  logic [15:0]     io_rdata,
    output logic            trap_take,
    output logic [PC_W-1:0] trap_pc,
    output logic [PC_W-1:0] epc,
    output logic [2:0]      cause,
    output logic            ie,
    output logic            in_handler
);

    localparam int STRIDE_SH = $clog2(VEC_STRIDE);

    // Vector address of a source; the stride is a power of two, so a shift.
    function automatic logic [PC_W-1:0] vec_addr(input logic [2:0] i);
        return VEC_BASE + (PC_W'(i) << STRIDE_SH);
    endfunction

    state_t      state;
    state_t      state_nxt;
    logic        enc_found;
    logic [2:0]  enc_idx;
    logic [2:0]  idx_q;
    logic        entry_allowed;
    logic        take_go;
    logic        rti_go;
    logic        rti_ie;
    logic        unused_rdata;

    // Only the pending bits of the read data carry meaning.
    assign unused_rdata = ^io_rdata[15:NIRQ];

    intr_prio_enc u_prio (
        .req   (io_rdata[NIRQ-1:0]),
        .found (enc_found),
        .idx   (enc_idx)
    );

    assign take_go = (state == TAKE);
    assign rti_go  = rti && in_handler;

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state decode and the bus/redirect strobes.
    always_comb begin
        state_nxt = state;
        io_req    = 1'b0;
        io_addr   = 4'd0;
        trap_take = 1'b0;
        case (state)
            IDLE: begin
                if (interrupt && ie && entry_allowed) state_nxt = REQ;
            end
            REQ: begin
                io_req  = 1'b1;
                io_addr = IO_PENDING_ADDR;
                // A zero snapshot means the source went away: give up.
                if (io_grant) state_nxt = enc_found ? WAIT : IDLE;
            end
            WAIT: begin
                if (insn_boundary) state_nxt = TAKE;
            end
            TAKE: begin
                trap_take = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Snapshot the winning source and its vector when the read completes.
    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q   <= 3'd0;
            trap_pc <= '0;
        end else if (state == REQ && io_grant && enc_found) begin
            idx_q   <= enc_idx;
            trap_pc <= vec_addr(enc_idx);
        end
    end

    // Interrupt enable: entry masks, software write beats return, return re-enables.
    always_ff @(posedge clk) begin
        if (reset)        ie <= 1'b0;
        else if (take_go) ie <= 1'b0;
        else if (ie_wr)   ie <= ie_wdata;
        else if (rti_go)  ie <= rti_ie;
    end

`ifdef INTR_ENTRY_NEST_EN

    logic [1:0]      depth;
    logic [PC_W-1:0] stk_epc0;
    logic [PC_W-1:0] stk_epc1;
    logic [2:0]      stk_cause0;
    logic [2:0]      stk_cause1;

    assign in_handler    = (depth != 2'd0);
    assign entry_allowed = !depth[1];
    // Returning into the outer handler keeps interrupts masked.
    assign rti_ie        = (depth != 2'd2);

    // Live {epc, cause} plus a two-deep save stack; a return in the entry
    // cycle pops then pushes, which just replaces the live values.
    always_ff @(posedge clk) begin
        if (reset) begin
            depth      <= 2'd0;
            epc        <= '0;
            cause      <= 3'd0;
            stk_epc0   <= '0;
            stk_epc1   <= '0;
            stk_cause0 <= 3'd0;
            stk_cause1 <= 3'd0;
        end else begin
            case ({take_go, rti_go})
                2'b10: begin
                    if (depth == 2'd0) begin
                        stk_epc0   <= epc;
                        stk_cause0 <= cause;
                    end else begin
                        stk_epc1   <= epc;
                        stk_cause1 <= cause;
                    end
                    epc   <= pc;
                    cause <= idx_q;
                    depth <= depth + 2'd1;
                end
                2'b01: begin
                    if (depth == 2'd1) begin
                        epc   <= stk_epc0;
                        cause <= stk_cause0;
                    end else begin
                        epc   <= stk_epc1;
                        cause <= stk_cause1;
                    end
                    depth <= depth - 2'd1;
                end
                2'b11: begin
                    epc   <= pc;
                    cause <= idx_q;
                end
                default: ;
            endcase
        end
    end

`else

    logic in_handler_q;

    assign in_handler    = in_handler_q;
    assign entry_allowed = !in_handler_q;
    assign rti_ie        = 1'b1;

    // Single-level save of return PC and cause; return just clears the flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            epc          <= '0;
            cause        <= 3'd0;
            in_handler_q <= 1'b0;
        end else if (take_go) begin
            epc          <= pc;
            cause        <= idx_q;
            in_handler_q <= 1'b1;
        end else if (rti_go) begin
            in_handler_q <= 1'b0;
        end
    end

`endif

endmodule

// File: tb/tb_intr_entry.sv
// Bench for intr_entry: directed scenarios followed by a randomized run
// scored against a rule-level model of enable, handler flag and traps.
module tb_intr_entry;

    logic        clk = 1'b0;
    logic        reset;
    logic        interrupt;
    logic        insn_boundary;
    logic [31:0] pc;
    logic        rti;
    logic        ie_wr;
    logic        ie_wdata;
    logic        io_req;
    logic        io_grant;
    logic [3:0]  io_addr;
    logic [15:0] io_rdata;
    logic        trap_take;
    logic [31:0] trap_pc;
    logic [31:0] epc;
    logic [2:0]  cause;
    logic        ie;
    logic        in_handler;

    int n_chk = 0;
    int n_bad = 0;

    intr_entry dut (
        .clk           (clk),
        .reset         (reset),
        .interrupt     (interrupt),
        .insn_boundary (insn_boundary),
        .pc            (pc),
        .rti           (rti),
        .ie_wr         (ie_wr),
        .ie_wdata      (ie_wdata),
        .io_req        (io_req),
        .io_grant      (io_grant),
        .io_addr       (io_addr),
        .io_rdata      (io_rdata),
        .trap_take     (trap_take),
        .trap_pc       (trap_pc),
        .epc           (epc),
        .cause         (cause),
        .ie            (ie),
        .in_handler    (in_handler)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Lowest set bit of the pending field, by isolating it arithmetically.
    function automatic int low_idx(input logic [4:0] v);
        logic [4:0] iso;
        int r;
        iso = v & (~v + 5'd1);
        r = 0;
        for (int k = 0; k < 5; k++)
            if (iso == (5'd1 << k)) r = k;
        return r;
    endfunction

    function automatic logic [31:0] vec_of(input int i);
        return 32'h0000_0100 + 32'(i) * 32'd16;
    endfunction

    task automatic quiet;
        interrupt = 0; insn_boundary = 0; rti = 0; ie_wr = 0; ie_wdata = 0;
        io_grant = 0; io_rdata = 16'h0; pc = 32'h0;
    endtask

    task automatic set_ie(input logic v);
        ie_wr = 1; ie_wdata = v;
        tick;
        ie_wr = 0; ie_wdata = 0;
    endtask

    task automatic do_rti;
        rti = 1;
        tick;
        rti = 0;
    endtask

    // Immediate grant and boundary: trap_take appears on the third edge.
    task automatic enter(input logic [15:0] rd, input logic [31:0] p, input string tag);
        interrupt = 1; io_grant = 1; io_rdata = rd; insn_boundary = 1; pc = p;
        tick; tick; tick;
        check({tag, "_take"}, 32'(trap_take), 32'd1);
        interrupt = 0;
        tick;
        io_grant = 0; insn_boundary = 0;
    endtask

    int          takes;
    int          seen;
    int          qi [$];
    logic        m_ie;
    logic        m_inh;
    logic [31:0] exp_epc;
    logic [2:0]  exp_cause;
    int          k;

    initial begin
        quiet();
        reset = 1;
        tick; tick;
        reset = 0;
        check("rst_io_req", 32'(io_req), 0);
        check("rst_trap_take", 32'(trap_take), 0);
        check("rst_trap_pc", trap_pc, 0);
        check("rst_epc", epc, 0);
        check("rst_misc", {27'd0, cause, ie, in_handler}, 0);

        // Basic entry with exact latency.
        set_ie(1);
        check("ie_set", 32'(ie), 1);
        interrupt = 1; io_grant = 1; io_rdata = 16'h0014; insn_boundary = 1; pc = 32'h2000;
        tick;
        check("basic_req", 32'(io_req), 1);
        check("basic_early1", 32'(trap_take), 0);
        tick;
        check("basic_early2", 32'(trap_take), 0);
        tick;
        check("basic_take", 32'(trap_take), 1);
        check("basic_trap_pc", trap_pc, 32'h0120);
        tick;
        check("basic_pulse", 32'(trap_take), 0);
        check("basic_epc", epc, 32'h2000);
        check("basic_cause", 32'(cause), 2);
        check("basic_ie", 32'(ie), 0);
        check("basic_inh", 32'(in_handler), 1);
        tick; tick;
        check("basic_block", 32'(io_req), 0);
        quiet();
        do_rti();
        check("rti_inh", 32'(in_handler), 0);
        check("rti_ie", 32'(ie), 1);

        // Grant withheld 4 cycles, boundary withheld 3 cycles.
        interrupt = 1; io_rdata = 16'h0001; pc = 32'h2400;
        tick;
        takes = 0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (io_req !== 1'b1) seen++;
            takes += int'(trap_take);
            tick;
        end
        if (io_req !== 1'b1) seen++;
        check("stall_req_held", 32'(seen), 0);
        io_grant = 1;
        tick;
        io_grant = 0;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            if (io_req !== 1'b0) seen++;
            takes += int'(trap_take);
            tick;
        end
        check("stall_req_drop", 32'(seen), 0);
        insn_boundary = 1;
        tick;
        check("stall_take", 32'(trap_take), 1);
        check("stall_trap_pc", trap_pc, 32'h0100);
        takes += int'(trap_take);
        interrupt = 0;
        tick;
        takes += int'(trap_take);
        insn_boundary = 0;
        check("stall_take_once", 32'(takes), 1);
        check("stall_cause", 32'(cause), 0);
        check("stall_epc", epc, 32'h2400);

        // Return paths.
        rti = 1; ie_wr = 1; ie_wdata = 0;
        tick;
        quiet();
        check("rti_wr_ie", 32'(ie), 0);
        check("rti_wr_inh", 32'(in_handler), 0);
        do_rti();
        check("rti_idle_ie", 32'(ie), 0);
        check("rti_idle_inh", 32'(in_handler), 0);
        check("rti_idle_epc", epc, 32'h2400);

        // Masked: ie=0 with interrupt high.
        interrupt = 1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            seen += int'(io_req);
        end
        check("mask_no_req", 32'(seen), 0);
        interrupt = 0;

        // Spurious read.
        set_ie(1);
        interrupt = 1; io_grant = 1; io_rdata = 16'h0000;
        tick;
        check("spur_req", 32'(io_req), 1);
        tick;
        check("spur_idle", 32'(io_req), 0);
        check("spur_no_take", 32'(trap_take), 0);
        tick;
        check("spur_rereq", 32'(io_req), 1);
        interrupt = 0;
        tick;
        io_grant = 0;
        check("spur_back", 32'(io_req), 0);
        check("spur_epc", epc, 32'h2400);
        check("spur_cause", 32'(cause), 0);
        tick;
        check("spur_take_none", 32'(trap_take), 0);

        // ie_wr coincident with TAKE.
        interrupt = 1; io_grant = 1; io_rdata = 16'h0010; insn_boundary = 1; pc = 32'h2800;
        tick; tick; tick;
        check("iewr_take", 32'(trap_take), 1);
        ie_wr = 1; ie_wdata = 1; interrupt = 0;
        tick;
        quiet();
        check("iewr_ie", 32'(ie), 0);
        check("iewr_cause", 32'(cause), 4);
        check("iewr_trap_pc", trap_pc, 32'h0140);
        check("iewr_epc", epc, 32'h2800);
        do_rti();
        check("iewr_rti_ie", 32'(ie), 1);

        // Reset while waiting for a boundary.
        interrupt = 1; io_grant = 1; io_rdata = 16'h0002; pc = 32'h2c00;
        tick; tick;
        check("rstw_in_wait", {30'd0, io_req, trap_take}, 0);
        reset = 1;
        tick;
        reset = 0;
        quiet();
        insn_boundary = 1;
        check("rstw_take", 32'(trap_take), 0);
        check("rstw_req", 32'(io_req), 0);
        check("rstw_trap_pc", trap_pc, 0);
        check("rstw_epc", epc, 0);
        check("rstw_misc", {27'd0, cause, ie, in_handler}, 0);
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick;
            seen += int'(trap_take);
        end
        check("rstw_no_take", 32'(seen), 0);
        insn_boundary = 0;

`ifdef INTR_ENTRY_NEST_EN
        // Two-level nesting.
        set_ie(1);
        enter(16'h0014, 32'h2000, "n1");
        check("n1_cause", 32'(cause), 2);
        check("n1_epc", epc, 32'h2000);
        set_ie(1);
        enter(16'h0001, 32'h3000, "n2");
        check("n2_cause", 32'(cause), 0);
        check("n2_epc", epc, 32'h3000);
        set_ie(1);
        interrupt = 1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            seen += int'(io_req);
        end
        check("n3_blocked", 32'(seen), 0);
        interrupt = 0;
        do_rti();
        check("pop1_epc", epc, 32'h2000);
        check("pop1_cause", 32'(cause), 2);
        check("pop1_ie", 32'(ie), 0);
        check("pop1_inh", 32'(in_handler), 1);
        do_rti();
        check("pop0_inh", 32'(in_handler), 0);
        check("pop0_ie", 32'(ie), 1);
`else
        // Randomized run against the rule model.
        reset = 1;
        tick;
        reset = 0;
        m_ie = 0; m_inh = 0; exp_epc = 0; exp_cause = 0;
        qi.delete();
        for (int c = 0; c < 3000; c++) begin
            if (c > 0) begin
                check("rnd_ie", 32'(ie), 32'(m_ie));
                check("rnd_inh", 32'(in_handler), 32'(m_inh));
                check("rnd_epc", epc, exp_epc);
                check("rnd_cause", 32'(cause), 32'(exp_cause));
            end
            interrupt     = ($urandom_range(0, 9) < 7);
            io_grant      = ($urandom_range(0, 9) < 6);
            insn_boundary = ($urandom_range(0, 1) == 1);
            io_rdata      = 16'($urandom);
            if ($urandom_range(0, 7) == 0) io_rdata[4:0] = 5'd0;
            pc            = $urandom & 32'hFFFF_FFFC;
            ie_wr         = ($urandom_range(0, 19) == 0);
            ie_wdata      = ($urandom_range(0, 3) != 0);
            rti           = ($urandom_range(0, 9) == 0);
            #1;
            if (io_req) check("rnd_addr", 32'(io_addr), 0);
            if (io_req && io_grant && io_rdata[4:0] != 5'd0)
                qi.push_back(low_idx(io_rdata[4:0]));
            if (trap_take) begin
                if (qi.size() == 0) begin
                    check("rnd_take_unexpected", 32'(trap_take), 0);
                end else begin
                    k = qi.pop_front();
                    check("rnd_trap_pc", trap_pc, vec_of(k));
                    exp_epc = pc;
                    exp_cause = 3'(k);
                end
            end
            if (trap_take)          m_ie = 0;
            else if (ie_wr)         m_ie = ie_wdata;
            else if (rti && m_inh)  m_ie = 1;
            if (trap_take)          m_inh = 1;
            else if (rti)           m_inh = 0;
            tick;
        end
        quiet();
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/intr_entry.md
Name: intr_entry

Overview:
- CPU-side consumer of the interrupt controller's `interrupt` line.
- Waits for the line while interrupts are enabled, then masters one io-bus read of the pending register (io_addr 0).
- Priority-encodes the result, waits for an instruction boundary, then redirects the core to a per-source vector, saving the return PC and cause.
- Sits between the core pipeline and the io bus arbiter.

Parameters:
- PC_W, 32, width of PC, vector and epc.
- VEC_BASE, 32'h0000_0100, address of the source-0 vector.
- VEC_STRIDE, 16, byte distance between vectors; must be a power of two.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- interrupt  in  1  level from interrupt controller (OR of pending)
- insn_boundary  in  1  core can accept a redirect this cycle
- pc  in  PC_W  PC of next instruction to execute at boundary
- rti  in  1  return-from-interrupt retired (1-cycle pulse)
- ie_wr  in  1  software write of interrupt-enable
- ie_wdata  in  1  value for ie_wr
- io_req  out  1  request io bus for a read
- io_grant  in  1  arbiter grant; io_rdata valid combinationally this cycle
- io_addr  out  4  read address (always 0 when io_req)
- io_rdata  in  16  read data; bits [4:0] pending
- trap_take  out  1  1-cycle redirect pulse
- trap_pc  out  PC_W  redirect target, valid with trap_take, held after
- epc  out  PC_W  saved return PC
- cause  out  3  index of serviced source
- ie  out  1  interrupt enable
- in_handler  out  1  handler active

Behaviour:
- Reset values: all outputs 0; FSM in IDLE.
- Reset mid-operation:
  - Aborts any sequence and drops io_req the next cycle.
  - No trap_take is issued.
- FSM states:
  - IDLE: go to REQ when interrupt && ie && entry_allowed. entry_allowed = !in_handler in the base build.
  - REQ:
    - io_req=1, io_addr=0.
    - On io_grant, register io_rdata[4:0] as snap.
    - If snap==0 (spurious, source cleared meanwhile), go to IDLE; otherwise go to WAIT.
    - While waiting for grant, io_req is held and the other outputs are unchanged.
  - WAIT:
    - idx = lowest set bit of snap; bit 0 (uart) has highest priority.
    - trap_pc = VEC_BASE + idx*VEC_STRIDE, registered on WAIT entry.
    - Stay until insn_boundary, then go to TAKE.
  - TAKE, one cycle:
    - trap_take=1.
    - epc<=pc, sampled the same cycle; pc is valid while insn_boundary.
    - cause<=idx, ie<=0, in_handler<=1.
    - Go to IDLE.
  - Latency: interrupt asserted with grant immediate and boundary immediate gives trap_take 3 cycles later.
- ie_wr: ie<=ie_wdata in any state except the TAKE cycle, where TAKE's ie<=0 wins.
- ie cleared after REQ has started: the sequence still completes. The decision is made at IDLE exit.
- rti:
  - Sets in_handler<=0 and ie<=1.
  - Ignored when !in_handler.
  - rti with ie_wr in the same cycle: ie_wr wins for ie; in_handler still clears.
- rti and TAKE can never coincide in the base build, because TAKE requires !in_handler at IDLE exit.
- No io writes: source acknowledge is the handler's responsibility.

Optional Feature:
- Macro: INTR_ENTRY_NEST_EN.
- Without it:
  - One level only.
  - in_handler blocks new entries even if software sets ie=1.
- With it:
  - 2-entry stack of {epc, cause}; entry_allowed = depth<2.
  - TAKE pushes the current {epc, cause} and loads the new ones.
  - rti pops: restores {epc, cause} and decrements depth.
  - in_handler = depth!=0.
  - rti popping to depth 1 sets ie<=0; popping to depth 0 sets ie<=1.
  - TAKE and rti in the same cycle: rti is processed first, then the push. Net depth is unchanged and the stack top is replaced.

Decomposition:
- Package intr_pkg:
  - NIRQ=5.
  - Source index constants: IRQ_UART=0, IRQ_CLOCK=1, IRQ_TIMER=2, IRQ_SWI=3, IRQ_SD=4.
  - IO_PENDING_ADDR=4'd0.
  - FSM state enum: IDLE, REQ, WAIT, TAKE.
- Sub-module intr_prio_enc: NIRQ-bit lowest-first priority encoder with outputs found and idx[2:0]; combinational, instantiated once.

Test Plan:
- Basic entry:
  - Stimulus: ie=1, interrupt=1, io_grant=1, io_rdata=16'h0014, insn_boundary=1, pc=32'h2000.
  - Response: trap_take 3 cycles after interrupt, cause=2, trap_pc=32'h0120, epc=32'h2000, ie=0.
- Grant and boundary stall:
  - Stimulus: io_grant withheld 4 cycles, then boundary withheld 3 cycles; io_rdata=16'h0001.
  - Response: io_req held throughout REQ; trap_take exactly once; cause=0, trap_pc=32'h0100.
- Spurious read:
  - Stimulus: io_rdata=16'h0000 at grant.
  - Response: back to IDLE, no trap_take, epc/cause unchanged; re-requests next cycle if interrupt is still high.
- Return path:
  - Stimulus: rti after entry.
  - Response: in_handler=0, ie=1.
  - Stimulus: rti with ie_wr=1, ie_wdata=0.
  - Response: ie=0.
  - Stimulus: rti while !in_handler.
  - Response: no change.
- Masking:
  - Stimulus: ie=0 with interrupt=1 for 10 cycles.
  - Response: io_req never asserts.
  - Stimulus: ie_wr coincident with TAKE.
  - Response: ie=0 afterwards.
  - Stimulus: reset asserted in WAIT.
  - Response: no trap_take; all outputs 0 the next cycle.
- Nesting (INTR_ENTRY_NEST_EN):
  - Stimulus: enter cause 2 (epc=32'h2000); set ie=1; enter cause 0 (epc=32'h3000).
  - Response: a third entry is blocked at depth 2.
  - Stimulus: rti.
  - Response: epc=32'h2000, cause=2, ie=0.
  - Stimulus: rti again.
  - Response: depth 0, ie=1.
